// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed frame in, natural-order burst out.
// Define FFT_REORDER_FRAME_MARK_EN to add registered osof/oeof frame markers.
module fft_bitrev_reorder #(
  parameter int FFT_STAGE  = 6,
  parameter int DATA_WIDTH = 16,
  parameter int BITREV     = 1
) (
  input  logic                  iclk,
  input  logic                  rstn,
  input  logic                  ien,
  input  logic [DATA_WIDTH-1:0] iReal,
  input  logic [DATA_WIDTH-1:0] iImag,
  output logic                  oen,
  output logic [DATA_WIDTH-1:0] oReal,
  output logic [DATA_WIDTH-1:0] oImag,
`ifdef FFT_REORDER_FRAME_MARK_EN
  output logic                  osof,
  output logic                  oeof,
`endif
  output logic                  obank
);

  localparam int AW = FFT_STAGE;
  localparam int N  = 1 << FFT_STAGE;
  localparam int EW = 2 * DATA_WIDTH;

  typedef enum logic {IDLE, READ} state_t;

  logic [EW-1:0] mem_q [0:2*N-1];

  logic [AW-1:0]         wcnt_q, wcnt_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            full_q, full_d;
  state_t                state_q, state_d;
  logic [AW-1:0]         rcnt_q, rcnt_d;
  logic                  oen_q, oen_d;
  logic [DATA_WIDTH-1:0] ore_q, ore_d;
  logic [DATA_WIDTH-1:0] oim_q, oim_d;
  logic                  obank_q, obank_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;

  logic [AW-1:0] waddr;
  logic          wlast;
  logic          rd;
  logic          rlast;
  logic          other_full;
  logic [EW-1:0] rdata;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  always_comb begin
    waddr  = (BITREV != 0) ? bitrev(wcnt_q) : wcnt_q;
    wlast  = ien && (wcnt_q == AW'(N-1));
    wcnt_d = ien ? wcnt_q + AW'(1) : wcnt_q;
    wbank_d = wbank_q ^ wlast;

    rd    = (state_q == READ);
    rlast = rd && (rcnt_q == AW'(N-1));
    rdata = mem_q[{rbank_q, rcnt_q}];

    full_d = full_q;
    if (wlast) full_d[wbank_q] = 1'b1;
    if (rlast) full_d[rbank_q] = 1'b0;

    // a bank completed on this very edge counts as already full
    other_full = full_q[~rbank_q] | (wlast && (wbank_q != rbank_q));

    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    unique case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (full_q[rbank_q]) state_d = READ;
      end
      READ: begin
        rcnt_d = rcnt_q + AW'(1);
        if (rlast) begin
          rbank_d = ~rbank_q;
          rcnt_d  = '0;
          state_d = other_full ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    oen_d   = rd;
    ore_d   = rd ? rdata[EW-1:DATA_WIDTH] : '0;
    oim_d   = rd ? rdata[DATA_WIDTH-1:0] : '0;
    obank_d = rd ? rbank_q : obank_q;
    sof_d   = rd && (rcnt_q == '0);
    eof_d   = rlast;
  end

  always_ff @(posedge iclk) begin
    if (rstn && ien) mem_q[{wbank_q, waddr}] <= {iReal, iImag};
  end

  always_ff @(posedge iclk) begin
    if (!rstn) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      full_q  <= '0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      oen_q   <= 1'b0;
      ore_q   <= '0;
      oim_q   <= '0;
      obank_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      oen_q   <= oen_d;
      ore_q   <= ore_d;
      oim_q   <= oim_d;
      obank_q <= obank_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign oen   = oen_q;
  assign oReal = ore_q;
  assign oImag = oim_q;
  assign obank = obank_q;

`ifdef FFT_REORDER_FRAME_MARK_EN
  assign osof = sof_q;
  assign oeof = eof_q;
`else
  logic unused_marks;
  assign unused_marks = sof_q ^ eof_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench: BITREV=1 and BITREV=0 instances fed the same stream.
module tb_fft_bitrev_reorder;

  localparam int FS = 6;
  localparam int N  = 64;
  localparam int DW = 16;

  logic          iclk = 1'b0;
  logic          rstn = 1'b0;
  logic          ien  = 1'b0;
  logic [DW-1:0] iReal = '0;
  logic [DW-1:0] iImag = '0;

  logic [1:0]    oen_w;
  logic [1:0]    ob_w;
  logic [DW-1:0] ore_w [2];
  logic [DW-1:0] oim_w [2];
`ifdef FFT_REORDER_FRAME_MARK_EN
  logic [1:0]    sof_w;
  logic [1:0]    eof_w;
`endif

  always #5 iclk = ~iclk;

  fft_bitrev_reorder #(.FFT_STAGE(FS), .DATA_WIDTH(DW), .BITREV(1)) dut1 (
    .iclk(iclk), .rstn(rstn), .ien(ien), .iReal(iReal), .iImag(iImag),
    .oen(oen_w[1]), .oReal(ore_w[1]), .oImag(oim_w[1]),
`ifdef FFT_REORDER_FRAME_MARK_EN
    .osof(sof_w[1]), .oeof(eof_w[1]),
`endif
    .obank(ob_w[1])
  );

  fft_bitrev_reorder #(.FFT_STAGE(FS), .DATA_WIDTH(DW), .BITREV(0)) dut0 (
    .iclk(iclk), .rstn(rstn), .ien(ien), .iReal(iReal), .iImag(iImag),
    .oen(oen_w[0]), .oReal(ore_w[0]), .oImag(oim_w[0]),
`ifdef FFT_REORDER_FRAME_MARK_EN
    .osof(sof_w[0]), .oeof(eof_w[0]),
`endif
    .obank(ob_w[0])
  );

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          bank;
    int            t;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t            q [2][$];
  logic [2*DW-1:0] fbuf [$];
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  int              last_start = -100000;
  logic            par = 1'b0;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < FS; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // reference model: frame collection in arrival order, burst timing from frame completion
  always @(posedge iclk) begin
    int st;
    exp_t e;
    cyc = cyc + 1;
    if (!rstn) begin
      fbuf.delete();
      q[0].delete();
      q[1].delete();
      par = 1'b0;
      last_start = -100000;
    end else if (ien) begin
      fbuf.push_back({iReal, iImag});
      if (fbuf.size() == N) begin
        st = (cyc <= last_start + N - 1) ? last_start + N : cyc + 2;
        for (int n = 0; n < N; n++) begin
          e.bank = par;
          e.t    = st + n;
          e.sof  = (n == 0);
          e.eof  = (n == N - 1);
          {e.re, e.im} = fbuf[brev(n)];
          q[1].push_back(e);
          {e.re, e.im} = fbuf[n];
          q[0].push_back(e);
        end
        par = ~par;
        last_start = st;
        fbuf.delete();
      end
    end
  end

  always @(negedge iclk) begin
    exp_t e;
    if (cyc >= 1) begin
      for (int d = 0; d < 2; d++) begin
        while (q[d].size() > 0 && q[d][0].t < cyc) begin
          e = q[d].pop_front();
          total++;
          bad++;
          $display("FAIL dut%0d_missing cyc=%0d got=none want=%0h", d, cyc, e.re);
        end
        if (oen_w[d] === 1'b1) begin
          if (q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut%0d_unexpected cyc=%0d got=%0h want=none", d, cyc, ore_w[d]);
          end else begin
            e = q[d].pop_front();
            cmp($sformatf("dut%0d_time", d), 64'(cyc), 64'(e.t));
            cmp($sformatf("dut%0d_re", d), 64'(ore_w[d]), 64'(e.re));
            cmp($sformatf("dut%0d_im", d), 64'(oim_w[d]), 64'(e.im));
            cmp($sformatf("dut%0d_bank", d), 64'(ob_w[d]), 64'(e.bank));
`ifdef FFT_REORDER_FRAME_MARK_EN
            cmp($sformatf("dut%0d_sof", d), 64'(sof_w[d]), 64'(e.sof));
            cmp($sformatf("dut%0d_eof", d), 64'(eof_w[d]), 64'(e.eof));
`endif
          end
        end else begin
          cmp($sformatf("dut%0d_oen", d), 64'(oen_w[d]), 64'(0));
          cmp($sformatf("dut%0d_idle_re", d), 64'(ore_w[d]), 64'(0));
          cmp($sformatf("dut%0d_idle_im", d), 64'(oim_w[d]), 64'(0));
`ifdef FFT_REORDER_FRAME_MARK_EN
          cmp($sformatf("dut%0d_idle_sof", d), 64'(sof_w[d]), 64'(0));
          cmp($sformatf("dut%0d_idle_eof", d), 64'(eof_w[d]), 64'(0));
`endif
        end
      end
    end
  end

  task automatic drive(input logic en, input logic [DW-1:0] re, input logic [DW-1:0] im);
    ien   = en;
    iReal = re;
    iImag = im;
    @(posedge iclk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    drive(1'b0, '0, '0);
    rstn = 1'b1;
  endtask

  task automatic drain();
    int i = 0;
    ien = 1'b0;
    while ((q[0].size() != 0 || q[1].size() != 0) && i < 500) begin
      @(posedge iclk);
      #1;
      i++;
    end
    cmp("drain_timeout", 64'(i < 500), 64'(1));
    repeat (4) drive(1'b0, DW'($urandom), DW'($urandom));
  endtask

  initial begin
    // reset held two edges with ien high
    rstn = 1'b0;
    drive(1'b1, DW'($urandom), DW'($urandom));
    drive(1'b1, DW'($urandom), DW'($urandom));
    for (int d = 0; d < 2; d++) begin
      cmp("rst_oen", 64'(oen_w[d]), 64'(0));
      cmp("rst_re", 64'(ore_w[d]), 64'(0));
      cmp("rst_im", 64'(oim_w[d]), 64'(0));
      cmp("rst_bank", 64'(ob_w[d]), 64'(0));
    end
    rstn = 1'b1;
    repeat (20) drive(1'b0, DW'($urandom), DW'($urandom));

    // single frame, ramp data
    for (int k = 0; k < N; k++) drive(1'b1, DW'(k), DW'(-k));
    drain();

    // three frames back-to-back from a fresh bank state
    pulse_reset();
    for (int k = 0; k < 3 * N; k++) drive(1'b1, DW'(k % N), DW'(-(k % N)));
    drain();

    // every-other-cycle input
    for (int k = 0; k < N; k++) begin
      drive(1'b1, DW'(k), DW'(-k));
      drive(1'b0, DW'($urandom), DW'($urandom));
    end
    drain();

    // reset in the middle of a frame
    for (int k = 0; k < 30; k++) drive(1'b1, DW'(500 + k), DW'($urandom));
    pulse_reset();
    for (int k = 0; k < N; k++) drive(1'b1, DW'(100 + k), DW'($urandom));
    drain();

    // random data with random gaps
    for (int f = 0; f < 6 * N; f++) begin
      while ($urandom_range(0, 3) == 0) drive(1'b0, DW'($urandom), DW'($urandom));
      drive(1'b1, DW'($urandom), DW'($urandom));
    end
    drain();

    // partial frame must stay silent
    for (int k = 0; k < 10; k++) drive(1'b1, DW'($urandom), DW'($urandom));
    repeat (150) drive(1'b0, DW'($urandom), DW'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
